// File: rtl/basic_cpu_p.sv
// Accumulator CPU running the basic-computer instruction set, one-hot T0..T6 sequencer over an async-read SRAM.
// Latency: 4 clocks for reg-ref/NOP, 5 for STA/BUN, 6 for AND/ADD/LDA/BSA, 7 for ISZ; indirect adds none.
// No backpressure: the SRAM is assumed always ready; after HLT all state freezes until reset.
module basic_cpu_p #(
    parameter int          DW       = 16,
    parameter int          AW       = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] data_in_i,
    output logic [AW-1:0] addr_o,
    output logic          we_o,
    output logic [DW-1:0] data_out_o,
    output logic          halted_o
);

    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);
    localparam logic [6:0]    SC_T0  = 7'b000_0001;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    logic [DW-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d;
    logic [AW-1:0] ar_q, ar_d, pc_q, pc_d;
    logic          e_q, e_d, i_q, i_d;
    logic          halted_q, halted_d;
    logic [6:0]    sc_q, sc_d;
    logic          we_c;
    logic [DW-1:0] wdat_c;

    logic [2:0]    op_w;
    logic [11:0]   rr_w;
    logic [DW:0]   sum_w;

    assign op_w  = ir_q[DW-2:DW-4];
    assign rr_w  = ir_q[11:0];
    assign sum_w = {1'b0, ac_q} + {1'b0, dr_q};

    // Sequencer step: decode the active timing slot and compute every next-state value.
    always_comb begin
        ir_d     = ir_q;
        dr_d     = dr_q;
        ac_d     = ac_q;
        ar_d     = ar_q;
        pc_d     = pc_q;
        e_d      = e_q;
        i_d      = i_q;
        halted_d = halted_q;
        sc_d     = {sc_q[5:0], 1'b0};
        we_c     = 1'b0;
        wdat_c   = '0;

        if (halted_q) begin
            // Frozen: nothing moves, no writes, addr holds.
            sc_d = sc_q;
        end else begin
            if (sc_q[0]) begin
                ar_d = pc_q;
            end
            if (sc_q[1]) begin
                ir_d = data_in_i;
                pc_d = pc_q + 1'b1;
            end
            if (sc_q[2]) begin
                i_d  = ir_q[DW-1];
                ar_d = ir_q[AW-1:0];
            end
            if (sc_q[3]) begin
                if (op_w == OP_REG) begin
                    sc_d = SC_T0;
                    if (!i_q) begin
                        // Only the highest set bit executes.
                        if (rr_w[11])      ac_d = '0;
                        else if (rr_w[10]) e_d  = 1'b0;
                        else if (rr_w[9])  ac_d = ~ac_q;
                        else if (rr_w[8])  e_d  = ~e_q;
                        else if (rr_w[7])  {ac_d, e_d} = {e_q, ac_q};
                        else if (rr_w[6])  {e_d, ac_d} = {ac_q, e_q};
                        else if (rr_w[5])  ac_d = ac_q + 1'b1;
                        else if (rr_w[4])  begin if (!ac_q[DW-1]) pc_d = pc_q + 1'b1; end
                        else if (rr_w[3])  begin if (ac_q[DW-1])  pc_d = pc_q + 1'b1; end
                        else if (rr_w[2])  begin if (ac_q == '0)  pc_d = pc_q + 1'b1; end
                        else if (rr_w[1])  begin if (!e_q)        pc_d = pc_q + 1'b1; end
                        else if (rr_w[0])  begin
                            halted_d = 1'b1;
                            sc_d     = sc_q;
                        end
                    end
                end else if (i_q) begin
                    ar_d = data_in_i[AW-1:0];
                end
            end
            if (sc_q[4]) begin
                case (op_w)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: dr_d = data_in_i;
                    OP_STA: begin
                        we_c   = 1'b1;
                        wdat_c = ac_q;
                        sc_d   = SC_T0;
                    end
                    OP_BUN: begin
                        pc_d = ar_q;
                        sc_d = SC_T0;
                    end
                    OP_BSA: begin
                        we_c   = 1'b1;
                        wdat_c = {{(DW-AW){1'b0}}, pc_q};
                        ar_d   = ar_q + 1'b1;
                    end
                    default: sc_d = SC_T0;
                endcase
            end
            if (sc_q[5]) begin
                sc_d = SC_T0;
                case (op_w)
                    OP_AND: ac_d = ac_q & dr_q;
                    OP_ADD: {e_d, ac_d} = sum_w;
                    OP_LDA: ac_d = dr_q;
                    OP_BSA: pc_d = ar_q;
                    OP_ISZ: begin
                        dr_d = dr_q + 1'b1;
                        sc_d = {sc_q[5:0], 1'b0};
                    end
                    default: ;
                endcase
            end
            if (sc_q[6]) begin
                // Only ISZ reaches T6.
                sc_d = SC_T0;
                if (op_w == OP_ISZ) begin
                    we_c   = 1'b1;
                    wdat_c = dr_q;
                    if (dr_q == '0) pc_d = pc_q + 1'b1;
                end
            end
        end
    end

    // Architectural state; async reset returns to T0 of a fresh fetch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_q     <= '0;
            dr_q     <= '0;
            ac_q     <= '0;
            ar_q     <= '0;
            pc_q     <= RST_PC;
            e_q      <= 1'b0;
            i_q      <= 1'b0;
            halted_q <= 1'b0;
            sc_q     <= SC_T0;
        end else begin
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            ac_q     <= ac_d;
            ar_q     <= ar_d;
            pc_q     <= pc_d;
            e_q      <= e_d;
            i_q      <= i_d;
            halted_q <= halted_d;
            sc_q     <= sc_d;
        end
    end

    assign addr_o     = ar_q;
    assign we_o       = we_c;
    assign data_out_o = wdat_c;
    assign halted_o   = halted_q;

endmodule

// File: tb/tb_basic_cpu_p.sv
// Directed bench for basic_cpu_p: default build plus a DW=20/AW=14 build, each on its own SRAM model.
// Latency: expectations are checked at fixed clock counts matching each instruction length.
// No backpressure: SRAM models read combinationally and write on the rising edge when we is high.
module tb_basic_cpu_p;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Default build (DW=16, AW=12, RESET_PC=0)
    logic [15:0] mem [0:4095];
    logic [11:0] addr;
    logic        we, halted;
    logic [15:0] din, dout;
    logic        clr = 1'b0, ld = 1'b0;
    logic [11:0] ld_a = '0;
    logic [15:0] ld_d = '0;
    int          we_cnt = 0;

    assign din = mem[addr];

    basic_cpu_p dut (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(din), .addr_o(addr),
        .we_o(we), .data_out_o(dout), .halted_o(halted)
    );

    // SRAM model for the default build, with bench-side clear/preload port.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (ld) begin
            mem[ld_a] <= ld_d;
        end else if (we) begin
            mem[addr] <= dout;
        end
        if (we) we_cnt <= we_cnt + 1;
    end

    // Wide build (DW=20, AW=14, RESET_PC=0x100)
    logic [19:0] memw [0:16383];
    logic [13:0] addr_w;
    logic        we_w, halted_w;
    logic [19:0] din_w, dout_w;
    logic        ldw = 1'b0;
    logic [13:0] ldw_a = '0;
    logic [19:0] ldw_d = '0;
    int          we_cnt_w = 0;

    assign din_w = memw[addr_w];

    basic_cpu_p #(.DW(20), .AW(14), .RESET_PC(32'h100)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(din_w), .addr_o(addr_w),
        .we_o(we_w), .data_out_o(dout_w), .halted_o(halted_w)
    );

    // SRAM model for the wide build.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16384; i++) memw[i] <= '0;
        end else if (ldw) begin
            memw[ldw_a] <= ldw_d;
        end else if (we_w) begin
            memw[addr_w] <= dout_w;
        end
        if (we_w) we_cnt_w <= we_cnt_w + 1;
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr   = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        ld_a = a; ld_d = d; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic pokew(input logic [13:0] a, input logic [19:0] d);
        ldw_a = a; ldw_d = d; ldw = 1'b1;
        @(negedge clk);
        ldw = 1'b0;
    endtask

    int c0;
    logic [11:0] held_addr;

    initial begin
        // ---- LDA/ADD with carry ----
        start_reset();
        poke(12'h000, 16'h2100);
        poke(12'h001, 16'h1101);
        poke(12'h100, 16'hFFFF);
        poke(12'h101, 16'h0001);
        chk("rst_addr", addr, 12'h000);
        chk("rst_we", we, 1'b0);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", dut.pc_q, 12'h000);
        rst_n = 1'b1;
        run(12);
        chk("add_ac", dut.ac_q, 16'h0000);
        chk("add_e", dut.e_q, 1'b1);
        chk("add_pc", dut.pc_q, 12'h002);

        // ---- Indirect STA ----
        start_reset();
        poke(12'h000, 16'h2010);
        poke(12'h010, 16'h1234);
        poke(12'h001, 16'hB200);
        poke(12'h200, 16'h0300);
        rst_n = 1'b1;
        run(6);
        c0 = we_cnt;
        run(3);
        chk("sta_t3_we", we, 1'b0);
        run(1);
        chk("sta_t4_we", we, 1'b1);
        chk("sta_t4_addr", addr, 12'h300);
        chk("sta_t4_dout", dout, 16'h1234);
        run(1);
        chk("sta_after_we", we, 1'b0);
        chk("sta_mem", mem[12'h300], 16'h1234);
        chk("sta_we_count", we_cnt - c0, 1);
        chk("sta_pc", dut.pc_q, 12'h002);

        // ---- Subroutine: BUN to 0x010, BSA 0x050, BUN I 0x050 ----
        start_reset();
        poke(12'h000, 16'h4010);
        poke(12'h010, 16'h5050);
        poke(12'h051, 16'hC050);
        rst_n = 1'b1;
        run(5);
        chk("bun_pc", dut.pc_q, 12'h010);
        c0 = we_cnt;
        run(6);
        chk("bsa_mem", mem[12'h050], 16'h0011);
        chk("bsa_pc", dut.pc_q, 12'h051);
        chk("bsa_we_count", we_cnt - c0, 1);
        run(5);
        chk("buni_pc", dut.pc_q, 12'h011);

        // ---- ISZ with skip ----
        start_reset();
        poke(12'h000, 16'h4020);
        poke(12'h020, 16'h6080);
        poke(12'h080, 16'hFFFF);
        rst_n = 1'b1;
        run(12);
        chk("isz_wrap_mem", mem[12'h080], 16'h0000);
        chk("isz_wrap_pc", dut.pc_q, 12'h022);

        // ---- ISZ without skip ----
        start_reset();
        poke(12'h000, 16'h4020);
        poke(12'h020, 16'h6080);
        poke(12'h080, 16'h0005);
        rst_n = 1'b1;
        run(12);
        chk("isz_mem", mem[12'h080], 16'h0006);
        chk("isz_pc", dut.pc_q, 12'h021);

        // ---- Register reference sequence ending in HLT ----
        start_reset();
        poke(12'h000, 16'h2010);   // LDA 0x010 -> AC=8001
        poke(12'h010, 16'h8001);
        poke(12'h001, 16'h7040);   // CIL
        poke(12'h002, 16'h7800);   // CLA
        poke(12'h003, 16'h7004);   // SZA -> skip 0x004
        poke(12'h004, 16'h7001);   // skipped HLT
        poke(12'h005, 16'h7020);   // INC -> AC=1
        poke(12'h006, 16'h7840);   // CLA wins over CIL
        poke(12'h007, 16'h7001);   // HLT
        rst_n = 1'b1;
        run(10);
        chk("cil_ac", dut.ac_q, 16'h0002);
        chk("cil_e", dut.e_q, 1'b1);
        run(8);
        chk("sza_pc", dut.pc_q, 12'h005);
        chk("sza_halted", halted, 1'b0);
        run(8);
        chk("cla_only_ac", dut.ac_q, 16'h0000);
        chk("cla_only_e", dut.e_q, 1'b1);
        run(4);
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_pc", dut.pc_q, 12'h008);
        held_addr = addr;
        chk("hlt_addr_value", held_addr, 12'h001);
        c0 = we_cnt;
        for (int k = 0; k < 20; k++) begin
            run(1);
            chk("hlt_we", we, 1'b0);
            chk("hlt_addr_hold", addr, held_addr);
        end
        chk("hlt_no_writes", we_cnt - c0, 0);
        chk("hlt_still_halted", halted, 1'b1);

        // ---- Reset mid-ISZ at T5, default build ----
        start_reset();
        poke(12'h000, 16'h6080);
        poke(12'h080, 16'h0041);
        rst_n = 1'b1;
        run(5);
        chk("misz_dr_before", dut.dr_q, 16'h0041);
        c0 = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("misz_rst_we", we, 1'b0);
        chk("misz_rst_addr", addr, 12'h000);
        chk("misz_rst_dout", dout, 16'h0000);
        chk("misz_rst_pc", dut.pc_q, 12'h000);
        chk("misz_rst_dr", dut.dr_q, 16'h0000);
        run(3);
        rst_n = 1'b1;
        run(2);
        chk("misz_no_write", we_cnt - c0, 0);
        chk("misz_mem", mem[12'h080], 16'h0041);

        // ---- Wide build: ADD wrap at 2^20, then reset mid-ISZ ----
        start_reset();
        pokew(14'h0100, 20'h20200);
        pokew(14'h0101, 20'h10201);
        pokew(14'h0102, 20'h60300);
        pokew(14'h0200, 20'hFFFFF);
        pokew(14'h0201, 20'h00003);
        pokew(14'h0300, 20'h12345);
        chk("w_rst_pc", dut_w.pc_q, 14'h0100);
        chk("w_rst_addr", addr_w, 14'h0000);
        rst_n = 1'b1;
        run(12);
        chk("w_add_ac", dut_w.ac_q, 20'h00002);
        chk("w_add_e", dut_w.e_q, 1'b1);
        chk("w_add_pc", dut_w.pc_q, 14'h0102);
        run(5);
        c0 = we_cnt_w;
        rst_n = 1'b0;
        #1;
        chk("w_rst_we", we_w, 1'b0);
        chk("w_rst_pc2", dut_w.pc_q, 14'h0100);
        chk("w_rst_ac", dut_w.ac_q, 20'h00000);
        run(2);
        rst_n = 1'b1;
        run(1);
        chk("w_t0_addr", addr_w, 14'h0100);
        chk("w_no_write", we_cnt_w - c0, 0);
        chk("w_mem", memw[14'h0300], 20'h12345);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
